// File: rtl/reset_sequencer_pkg.sv
// Shared FSM encoding and parameter-legality helper for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SWRST   = 3'd4
  } state_t;

  // True when every programmed interval fits in the counter without wrapping.
  function automatic bit params_ok(input int num_ch, input int sync_stages,
                                   input int hold_cycles, input int stagger,
                                   input int pulse_cycles, input int cnt_w);
    longint cnt_max;
    if (num_ch < 1 || sync_stages < 2 || hold_cycles < 0 || stagger < 0 || pulse_cycles < 1)
      return 1'b0;
    if (cnt_w < 1 || cnt_w > 32)
      return 1'b0;
    cnt_max = (longint'(1) << cnt_w) - 1;
    return (longint'(hold_cycles) <= cnt_max) &&
           (longint'(stagger) * longint'(num_ch - 1) <= cnt_max) &&
           (longint'(pulse_cycles) <= cnt_max);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser chain.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic arm,
  output logic rst_sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], 1'b1};
  end

  // arm is the last stage's input: high one edge before rst_sync rises.
  assign arm      = chain[STAGES-2];
  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised board reset, settle hold, staggered domain
// release and software-requested reset pulses.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 20,
  parameter int STAGGER      = 8,
  parameter int PULSE_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] sw_ch_mask_i,
  input  logic              sw_mod_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              mod_rst_o,
  output logic              ready_o,
  output logic              busy_o
);

  if (!params_ok(NUM_CH, SYNC_STAGES, HOLD_CYCLES, STAGGER, PULSE_CYCLES, CNT_W)) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  // Count value seen on the cycle whose closing edge ends the interval.
  localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
  logic [NUM_CH-1:0] ch_d, mask_q, mask_d, rel_hit;
  logic              mod_d, mod_flag_q, mod_flag_d, ready_d;
  logic              arm, rst_sync;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk      (sys_clk_i),
    .rst_n    (sys_rst_i),
    .arm      (arm),
    .rst_sync (rst_sync)
  );

  // Channel k releases once the post-edge release count reaches k*STAGGER.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
    localparam int unsigned REL_AT = k * STAGGER;
    if (REL_AT == 0) begin : g_first
      assign rel_hit[k] = 1'b1;
    end else begin : g_later
      assign rel_hit[k] = (state == ST_RELEASE) && ((32'(cnt) + 32'd1) >= REL_AT);
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ch_d       = ch_rst_o;
    mod_d      = mod_rst_o;
    mask_d     = mask_q;
    mod_flag_d = mod_flag_q;
    cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    case (state)
      ST_RESET: begin
        if (arm && !rst_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt == HOLD_LAST) begin
          cnt_d = '0;
          ch_d  = ch_rst_o & ~rel_hit;
          if (rel_hit[NUM_CH-1]) begin
            state_d = ST_RUN;
            mod_d   = 1'b0;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        cnt_d = cnt_inc;
        ch_d  = ch_rst_o & ~rel_hit;
        if (rel_hit[NUM_CH-1]) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mod_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (sw_rst_req_i && ((|sw_ch_mask_i) || sw_mod_i)) begin
          state_d    = ST_SWRST;
          cnt_d      = '0;
          mask_d     = sw_ch_mask_i;
          mod_flag_d = sw_mod_i;
          ch_d       = ch_rst_o | sw_ch_mask_i;
          mod_d      = sw_mod_i;
        end
      end
      ST_SWRST: begin
        cnt_d = cnt_inc;
        if (cnt == PULSE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ch_d    = ch_rst_o & ~mask_q;
          if (mod_flag_q) mod_d = 1'b0;
        end
      end
      default: state_d = ST_RESET;
    endcase

    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state      <= ST_RESET;
      cnt        <= '0;
      ch_rst_o   <= '1;
      mod_rst_o  <= 1'b1;
      ready_o    <= 1'b0;
      busy_o     <= 1'b1;
      mask_q     <= '0;
      mod_flag_q <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ch_rst_o   <= ch_d;
      mod_rst_o  <= mod_d;
      ready_o    <= ready_d;
      busy_o     <= !ready_d;
      mask_q     <= mask_d;
      mod_flag_q <= mod_flag_d;
    end
  end

endmodule
